// File: rtl/mult_pkg.sv
// Shared definitions for the 4-bit shift-add multiplier unit.
// Holds the controller state encoding and the default operand / counter
// widths, which the datapath uses as well.
package mult_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int CNT_W_DEF = 3;

  // 3-bit binary encoding. Codes 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_TEST  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/mult_bit_counter.sv
// Loadable iteration down-counter for the multiplier controller.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (cnt -> 0)
//   load     : load cnt with WIDTH
//   dec      : decrement cnt; ignored when cnt is already 0 so it never wraps
//   cnt      : current count
//   last     : cnt == 1, i.e. the shift now in progress is the final one
module mult_bit_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(WIDTH);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/mult_controller.sv
// Control FSM for the shift-add multiplier datapath.
// Handshake: start is accepted only in IDLE (operands must be valid on the
// datapath inputs in that cycle). done is held high until done_ack is seen
// in DONE; an ack returns to IDLE, and start must be raised again there.
// All outputs are Moore, decoded from the state register only.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : multiply request (IDLE only)
//   done_ack  : result consumed (DONE only)
//   q0        : datapath multiplier LSB, sampled in TEST
//   ld_regs   : datapath load strobe
//   add_en    : datapath accumulate strobe
//   shift_en  : datapath shift strobe
//   busy      : LOAD through SHIFT
//   done      : product valid, held until done_ack
//   state_dbg : current state register, for observation
module mult_controller
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done_ack,
  input  logic       q0,
  output logic       ld_regs,
  output logic       add_en,
  output logic       shift_en,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  state_t           state_q;
  state_t           state_d;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt;

  mult_bit_counter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .cnt  (cnt),
    .last (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and counter controls. The counter controls depend on the
  // state only, so they are as glitch-free as the Moore strobes.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_LOAD;
      S_LOAD: begin
        cnt_load = 1'b1;
        state_d  = S_TEST;
      end
      S_TEST:  state_d = q0 ? S_ADD : S_SHIFT;
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: begin
        cnt_dec = 1'b1;
        state_d = cnt_last ? S_DONE : S_TEST;
      end
      S_DONE:  if (done_ack) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; unencoded states drive everything low.
  always_comb begin
    ld_regs  = 1'b0;
    add_en   = 1'b0;
    shift_en = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_LOAD: begin
        ld_regs = 1'b1;
        busy    = 1'b1;
      end
      S_TEST:  busy = 1'b1;
      S_ADD: begin
        add_en = 1'b1;
        busy   = 1'b1;
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        busy     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_q;

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_mult_controller.sv
// Directed bench for mult_controller, with a small behavioural shift-add
// datapath in the bench so products can be checked end to end.
module tb_mult_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic       done_ack;
  logic       q0;
  logic       ld_regs;
  logic       add_en;
  logic       shift_en;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // operands and behavioural datapath
  logic [3:0] mr_in;
  logic [3:0] md_in;
  logic [4:0] acc;
  logic [3:0] qr;
  logic [3:0] mreg;
  logic [7:0] product;

  mult_controller dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .done_ack  (done_ack),
    .q0        (q0),
    .ld_regs   (ld_regs),
    .add_en    (add_en),
    .shift_en  (shift_en),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      qr   <= '0;
      mreg <= '0;
    end else if (ld_regs) begin
      acc  <= '0;
      qr   <= mr_in;
      mreg <= md_in;
    end else if (add_en) begin
      acc <= {1'b0, acc[3:0]} + {1'b0, mreg};
    end else if (shift_en) begin
      qr  <= {acc[0], qr[3:1]};
      acc <= acc >> 1;
    end
  end

  assign q0      = qr[0];
  assign product = {acc[3:0], qr};

  // Issue one operation and wait for done. Counts strobes at each negedge.
  task automatic run_op(input logic [3:0] mr, input logic [3:0] md,
                        input int exp_lat, input int exp_add,
                        input logic [7:0] exp_p, input bit poke_start,
                        input string name);
    int cyc;
    int n_ld;
    int n_add;
    int n_sh;
    int n_ovl;
    cyc = 0; n_ld = 0; n_add = 0; n_sh = 0; n_ovl = 0;
    @(negedge clk);
    mr_in = mr;
    md_in = md;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      n_ld  += int'(ld_regs);
      n_add += int'(add_en);
      n_sh  += int'(shift_en);
      if (int'(ld_regs) + int'(add_en) + int'(shift_en) > 1) n_ovl++;
      if (poke_start && (cyc == 3 || cyc == 4)) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done=%0b after %0d cycles, required 1", name, done, cyc);
    end
    checks++;
    if (cyc - 1 !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, cyc - 1, exp_lat);
    end
    checks++;
    if (n_ld !== 1) begin
      errors++;
      $display("FAIL %s ld_count: got %0d required 1", name, n_ld);
    end
    checks++;
    if (n_add !== exp_add) begin
      errors++;
      $display("FAIL %s add_count: got %0d required %0d", name, n_add, exp_add);
    end
    checks++;
    if (n_sh !== 4) begin
      errors++;
      $display("FAIL %s shift_count: got %0d required 4", name, n_sh);
    end
    checks++;
    if (n_ovl !== 0) begin
      errors++;
      $display("FAIL %s overlap: got %0d overlapping cycles required 0", name, n_ovl);
    end
    checks++;
    if (product !== exp_p) begin
      errors++;
      $display("FAIL %s product: got %h required %h", name, product, exp_p);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_in_done: got %0b required 0", name, busy);
    end
  endtask

  task automatic do_ack(input string name);
    done_ack = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
    checks++;
    if (done !== 1'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL %s ack: done=%0b state=%0d required done=0 state=0", name, done, state_dbg);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #15;
    checks++;
    if ({ld_regs, add_en, shift_en, busy, done} !== 5'b0 || state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b state %0d required 00000 state 0",
               {ld_regs, add_en, shift_en, busy, done}, state_dbg);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ld_regs, add_en, shift_en, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle: got %b required 00000", {ld_regs, add_en, shift_en, busy, done});
    end
  endtask

  task automatic test_basic();
    run_op(4'b1011, 4'b0101, 12, 3, 8'h37, 1'b0, "basic");
    do_ack("basic");
  endtask

  task automatic test_zero();
    run_op(4'b0000, 4'b1111, 9, 0, 8'h00, 1'b0, "zero");
    do_ack("zero");
  endtask

  task automatic test_all_ones();
    run_op(4'b1111, 4'b1111, 13, 4, 8'hE1, 1'b0, "ones");
    do_ack("ones");
  endtask

  // start pulsed mid-operation and in DONE; done_ack withheld 20 cycles
  task automatic test_start_ignored();
    int bad;
    bad = 0;
    run_op(4'b0110, 4'b0011, 11, 2, 8'h12, 1'b1, "poke");
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      @(negedge clk);
      if (done !== 1'b1 || ld_regs || add_en || shift_en || busy) bad++;
    end
    start = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL done_hold: got %0d bad cycles required 0", bad);
    end
    do_ack("hold");
  endtask

  task automatic test_ack_start();
    int n_ld;
    n_ld = 0;
    run_op(4'b0001, 4'b0111, 10, 1, 8'h07, 1'b0, "ackstart");
    done_ack = 1'b1;
    start    = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
    start    = 1'b0;
    checks++;
    if (state_dbg !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ack_start_idle: state=%0d done=%0b required state=0 done=0", state_dbg, done);
    end
    repeat (3) begin
      @(negedge clk);
      n_ld += int'(ld_regs) + int'(busy);
    end
    checks++;
    if (n_ld !== 0) begin
      errors++;
      $display("FAIL ack_start_noload: got %0d active cycles required 0", n_ld);
    end
  endtask

  task automatic test_rst_mid();
    int bad;
    int guard;
    bad = 0;
    guard = 0;
    @(negedge clk);
    mr_in = 4'b1011;
    md_in = 4'b0101;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!add_en && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!add_en) begin
      errors++;
      $display("FAIL rst_mid_reach_add: add_en=%0b required 1", add_en);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ld_regs, add_en, shift_en, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got %b required 00000", {ld_regs, add_en, shift_en, busy, done});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if ({ld_regs, add_en, shift_en, busy, done} !== 5'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %0d active cycles required 0", bad);
    end
    run_op(4'b1011, 4'b0101, 12, 3, 8'h37, 1'b0, "after_rst");
    do_ack("after_rst");
  endtask

  initial begin
    start    = 1'b0;
    done_ack = 1'b0;
    mr_in    = '0;
    md_in    = '0;
    test_reset();
    test_basic();
    test_zero();
    test_all_ones();
    test_start_ignored();
    test_ack_start();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
